// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the FSM state and instruction-class enums, the datapath mux
// encodings (reg_dst, alu_src2, pc_src, mem_size), and local copies of the
// core's ALUOp and opcode/funct/rt constants so this slice builds stand-alone.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsAluR,
    ClsAluI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsJumpR,
    ClsSyscall,
    ClsIllegal
  } cls_e;

  // reg_dst
  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  // alu_src2
  localparam logic [1:0] AluSrc2Rt   = 2'd0;
  localparam logic [1:0] AluSrc2SImm = 2'd1;
  localparam logic [1:0] AluSrc2ZImm = 2'd2;
  localparam logic [1:0] AluSrc2Four = 2'd3;

  // pc_src
  localparam logic [1:0] PcSrcSeq    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcReg    = 2'd3;

  // mem_size
  localparam logic [1:0] MemSizeByte = 2'd0;
  localparam logic [1:0] MemSizeHalf = 2'd1;
  localparam logic [1:0] MemSizeWord = 2'd2;

  // ALUOp
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluAnd  = 4'd2;
  localparam logic [3:0] AluOr   = 4'd3;
  localparam logic [3:0] AluXor  = 4'd4;
  localparam logic [3:0] AluNor  = 4'd5;
  localparam logic [3:0] AluSlt  = 4'd6;
  localparam logic [3:0] AluSltu = 4'd7;
  localparam logic [3:0] AluSll  = 4'd8;
  localparam logic [3:0] AluSrl  = 4'd9;
  localparam logic [3:0] AluSra  = 4'd10;
  localparam logic [3:0] AluLui  = 4'd11;

  // Opcodes
  localparam logic [5:0] OpRtype  = 6'h00;
  localparam logic [5:0] OpRegimm = 6'h01;
  localparam logic [5:0] OpJ      = 6'h02;
  localparam logic [5:0] OpJal    = 6'h03;
  localparam logic [5:0] OpBeq    = 6'h04;
  localparam logic [5:0] OpBne    = 6'h05;
  localparam logic [5:0] OpBlez   = 6'h06;
  localparam logic [5:0] OpBgtz   = 6'h07;
  localparam logic [5:0] OpAddi   = 6'h08;
  localparam logic [5:0] OpAddiu  = 6'h09;
  localparam logic [5:0] OpSlti   = 6'h0A;
  localparam logic [5:0] OpSltiu  = 6'h0B;
  localparam logic [5:0] OpAndi   = 6'h0C;
  localparam logic [5:0] OpOri    = 6'h0D;
  localparam logic [5:0] OpXori   = 6'h0E;
  localparam logic [5:0] OpLui    = 6'h0F;
  localparam logic [5:0] OpLb     = 6'h20;
  localparam logic [5:0] OpLh     = 6'h21;
  localparam logic [5:0] OpLw     = 6'h23;
  localparam logic [5:0] OpLbu    = 6'h24;
  localparam logic [5:0] OpLhu    = 6'h25;
  localparam logic [5:0] OpSb     = 6'h28;
  localparam logic [5:0] OpSh     = 6'h29;
  localparam logic [5:0] OpSw     = 6'h2B;

  // R-type funct
  localparam logic [5:0] FnSll     = 6'h00;
  localparam logic [5:0] FnSrl     = 6'h02;
  localparam logic [5:0] FnSra     = 6'h03;
  localparam logic [5:0] FnSllv    = 6'h04;
  localparam logic [5:0] FnSrlv    = 6'h06;
  localparam logic [5:0] FnSrav    = 6'h07;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;
  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnAddu    = 6'h21;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnSubu    = 6'h23;
  localparam logic [5:0] FnAnd     = 6'h24;
  localparam logic [5:0] FnOr      = 6'h25;
  localparam logic [5:0] FnXor     = 6'h26;
  localparam logic [5:0] FnNor     = 6'h27;
  localparam logic [5:0] FnSlt     = 6'h2A;
  localparam logic [5:0] FnSltu    = 6'h2B;

  // REGIMM rt
  localparam logic [4:0] RtBltz   = 5'h00;
  localparam logic [4:0] RtBgez   = 5'h01;
  localparam logic [4:0] RtBltzal = 5'h10;
  localparam logic [4:0] RtBgezal = 5'h11;

endpackage

// File: rtl/mips_decode_cls.sv
// Combinational instruction classifier.
// Inputs : op_code, rt, funct (IR fields)
// Outputs: cls (instruction class), alu_op, alu_src1, alu_src2,
//          mem_size, mem_signed, link (instruction writes a return address)
module mips_decode_cls
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic [3:0] alu_op,
  output logic       alu_src1,
  output logic [1:0] alu_src2,
  output logic [1:0] mem_size,
  output logic       mem_signed,
  output logic       link
);

  always_comb begin
    cls        = ClsIllegal;
    alu_op     = AluAdd;
    alu_src1   = 1'b0;
    alu_src2   = AluSrc2Rt;
    mem_size   = MemSizeWord;
    mem_signed = 1'b0;
    link       = 1'b0;
    case (op_code)
      OpRtype: begin
        cls = ClsAluR;
        case (funct)
          FnSll:          begin alu_op = AluSll; alu_src1 = 1'b1; end
          FnSrl:          begin alu_op = AluSrl; alu_src1 = 1'b1; end
          FnSra:          begin alu_op = AluSra; alu_src1 = 1'b1; end
          FnSllv:         alu_op = AluSll;
          FnSrlv:         alu_op = AluSrl;
          FnSrav:         alu_op = AluSra;
          FnJr:           cls = ClsJumpR;
          FnJalr:         begin cls = ClsJumpR; link = 1'b1; end
          FnSyscall:      cls = ClsSyscall;
          FnAdd, FnAddu:  alu_op = AluAdd;
          FnSub, FnSubu:  alu_op = AluSub;
          FnAnd:          alu_op = AluAnd;
          FnOr:           alu_op = AluOr;
          FnXor:          alu_op = AluXor;
          FnNor:          alu_op = AluNor;
          FnSlt:          alu_op = AluSlt;
          FnSltu:         alu_op = AluSltu;
          default:        cls = ClsIllegal;
        endcase
      end
      OpRegimm: begin
        cls    = ClsBranch;
        alu_op = AluSub;
        case (rt)
          RtBltz, RtBgez:     ;
          RtBltzal, RtBgezal: link = 1'b1;
          default:            cls = ClsIllegal;
        endcase
      end
      OpJ:                         cls = ClsJump;
      OpJal:                       begin cls = ClsJump; link = 1'b1; end
      OpBeq, OpBne, OpBlez, OpBgtz: begin cls = ClsBranch; alu_op = AluSub; end
      OpAddi, OpAddiu: begin cls = ClsAluI; alu_src2 = AluSrc2SImm; end
      OpSlti:  begin cls = ClsAluI; alu_op = AluSlt;  alu_src2 = AluSrc2SImm; end
      OpSltiu: begin cls = ClsAluI; alu_op = AluSltu; alu_src2 = AluSrc2SImm; end
      OpAndi:  begin cls = ClsAluI; alu_op = AluAnd;  alu_src2 = AluSrc2ZImm; end
      OpOri:   begin cls = ClsAluI; alu_op = AluOr;   alu_src2 = AluSrc2ZImm; end
      OpXori:  begin cls = ClsAluI; alu_op = AluXor;  alu_src2 = AluSrc2ZImm; end
      OpLui:   begin cls = ClsAluI; alu_op = AluLui;  alu_src2 = AluSrc2ZImm; end
      OpLb:  begin cls = ClsLoad; alu_src2 = AluSrc2SImm; mem_size = MemSizeByte; mem_signed = 1'b1; end
      OpLh:  begin cls = ClsLoad; alu_src2 = AluSrc2SImm; mem_size = MemSizeHalf; mem_signed = 1'b1; end
      OpLw:  begin cls = ClsLoad; alu_src2 = AluSrc2SImm; mem_size = MemSizeWord; end
      OpLbu: begin cls = ClsLoad; alu_src2 = AluSrc2SImm; mem_size = MemSizeByte; end
      OpLhu: begin cls = ClsLoad; alu_src2 = AluSrc2SImm; mem_size = MemSizeHalf; end
      OpSb:  begin cls = ClsStore; alu_src2 = AluSrc2SImm; mem_size = MemSizeByte; end
      OpSh:  begin cls = ClsStore; alu_src2 = AluSrc2SImm; mem_size = MemSizeHalf; end
      OpSw:  begin cls = ClsStore; alu_src2 = AluSrc2SImm; mem_size = MemSizeWord; end
      default: cls = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle control FSM for the lab MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes and mux
// selects combinationally from state, latched class and IR fields.
// Params : MEM_HANDSHAKE (1 = wait on mem_ready), WAIT_MAX (1..255 wait cycles)
// Inputs : clk, rst (async, active-high), op_code, rt, funct, mem_ready, br_taken
// Outputs: pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
//          reg_dst, alu_op, alu_src1, alu_src2, pc_src, mem_size, mem_signed,
//          halted, illegal, mem_err
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned WAIT_MAX      = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_code,
  input  logic [4:0] rt,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic [3:0] alu_op,
  output logic       alu_src1,
  output logic [1:0] alu_src2,
  output logic [1:0] pc_src,
  output logic [1:0] mem_size,
  output logic       mem_signed,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err
);

  localparam logic [7:0] WaitLimit = 8'(WAIT_MAX);

  state_e     state_q;
  cls_e       cls_q;
  logic [7:0] wait_q;
  logic       illegal_q;
  logic       mem_err_q;

  cls_e       dec_cls;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src1;
  logic [1:0] dec_alu_src2;
  logic [1:0] dec_mem_size;
  logic       dec_mem_signed;
  logic       dec_link;

  mips_decode_cls u_decode (
    .op_code    (op_code),
    .rt         (rt),
    .funct      (funct),
    .cls        (dec_cls),
    .alu_op     (dec_alu_op),
    .alu_src1   (dec_alu_src1),
    .alu_src2   (dec_alu_src2),
    .mem_size   (dec_mem_size),
    .mem_signed (dec_mem_signed),
    .link       (dec_link)
  );

  // Access completes this cycle; ready beats the timeout when both coincide.
  logic mem_done;
  logic timeout;
  assign mem_done = !MEM_HANDSHAKE || mem_ready;
  assign timeout  = MEM_HANDSHAKE && !mem_ready && (wait_q == WaitLimit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      cls_q     <= ClsIllegal;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      // Counter idles at zero so every FETCH/MEM entry starts from a clean count.
      wait_q <= '0;
      case (state_q)
        StFetch, StMem: begin
          if (mem_done) begin
            if (state_q == StFetch)    state_q <= StDecode;
            else if (cls_q == ClsLoad) state_q <= StWb;
            else                       state_q <= StFetch;
          end else if (timeout) begin
            state_q   <= StHalt;
            mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDecode: begin
          cls_q <= dec_cls;
          case (dec_cls)
            ClsJump, ClsJumpR: state_q <= StFetch;
            ClsSyscall:        state_q <= StHalt;
            ClsIllegal: begin
              state_q   <= StHalt;
              illegal_q <= 1'b1;
            end
            default:           state_q <= StExec;
          endcase
        end
        StExec: begin
          if (cls_q == ClsBranch)                           state_q <= StFetch;
          else if (cls_q == ClsLoad || cls_q == ClsStore)   state_q <= StMem;
          else                                              state_q <= StWb;
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = RegDstRt;
    alu_op     = AluAdd;
    alu_src1   = 1'b0;
    alu_src2   = AluSrc2Rt;
    pc_src     = PcSrcSeq;
    mem_size   = MemSizeWord;
    mem_signed = 1'b0;
    // Gating on rst keeps strobes low for the whole reset pulse, not just after the edge.
    if (!rst) begin
      case (state_q)
        StFetch: begin
          mem_read = !timeout;
          alu_src2 = AluSrc2Four;
          ir_write = mem_done;
          pc_write = mem_done;
        end
        StDecode: begin
          case (dec_cls)
            ClsJump: begin
              pc_write  = 1'b1;
              pc_src    = PcSrcJump;
              reg_write = dec_link;
              reg_dst   = RegDstRa;
            end
            ClsJumpR: begin
              pc_write  = 1'b1;
              pc_src    = PcSrcReg;
              reg_write = dec_link;
              reg_dst   = RegDstRd;
            end
            default: ;
          endcase
        end
        StExec: begin
          alu_op   = dec_alu_op;
          alu_src1 = dec_alu_src1;
          alu_src2 = dec_alu_src2;
          if (cls_q == ClsBranch) begin
            pc_src    = PcSrcBranch;
            pc_write  = br_taken;
            reg_write = dec_link;
            reg_dst   = RegDstRa;
          end
        end
        StMem: begin
          alu_op     = dec_alu_op;
          alu_src1   = dec_alu_src1;
          alu_src2   = dec_alu_src2;
          mem_size   = dec_mem_size;
          mem_signed = dec_mem_signed;
          if (cls_q == ClsLoad) mem_read  = !timeout;
          else                  mem_write = !timeout;
        end
        StWb: begin
          alu_op     = dec_alu_op;
          alu_src1   = dec_alu_src1;
          alu_src2   = dec_alu_src2;
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == ClsLoad);
          reg_dst    = (cls_q == ClsAluR) ? RegDstRd : RegDstRt;
        end
        default: ;
      endcase
    end
  end

  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign mem_err = mem_err_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized self-checking bench for mips_mc_ctrl. A per-instruction cycle
// schedule (fetch waits, decode, exec, mem waits, write-back) is derived from
// the instruction class and compared against DUT outputs every cycle.
module tb_mips_mc_ctrl;
  import mips_ctrl_pkg::*;

  localparam int WaitMax = 4;

  logic       clk, rst;
  logic [5:0] op_code, funct;
  logic [4:0] rt;
  logic       mem_ready, br_taken;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg;
  logic [1:0] reg_dst, alu_src2, pc_src, mem_size;
  logic [3:0] alu_op;
  logic       alu_src1, mem_signed, halted, illegal, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mips_mc_ctrl #(.MEM_HANDSHAKE(1'b1), .WAIT_MAX(WaitMax)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_code    (op_code),
    .rt         (rt),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .br_taken   (br_taken),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .alu_op     (alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .pc_src     (pc_src),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .halted     (halted),
    .illegal    (illegal),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg;
    logic [1:0] reg_dst;
    logic [3:0] alu_op;
    logic       alu_src1;
    logic [1:0] alu_src2, pc_src, mem_size;
    logic       mem_signed, halted, illegal, mem_err;
  } outs_t;

  typedef enum logic [3:0] {KAluR, KAluI, KLoad, KStore, KBranch, KJump, KJumpR, KSys, KIll} kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       link;
    logic [3:0] aop;
    logic       src1;
    logic [1:0] src2;
    logic [1:0] msize;
    logic       msigned;
  } ref_t;

  localparam logic [5:0] LegalOps [24] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
    6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23,
    6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
  localparam logic [5:0] LegalFns [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
    6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h21, 6'h20};
  localparam logic [4:0] LegalRts [4] = '{5'h00, 5'h01, 5'h10, 5'h11};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t op=%h rt=%h fn=%h)", tag, got, exp, $time,
               op_code, rt, funct);
    end
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.pc_write = pc_write;   o.ir_write = ir_write;   o.reg_write = reg_write;
    o.mem_read = mem_read;   o.mem_write = mem_write; o.mem_to_reg = mem_to_reg;
    o.reg_dst = reg_dst;     o.alu_op = alu_op;       o.alu_src1 = alu_src1;
    o.alu_src2 = alu_src2;   o.pc_src = pc_src;       o.mem_size = mem_size;
    o.mem_signed = mem_signed; o.halted = halted;     o.illegal = illegal;
    o.mem_err = mem_err;
    return o;
  endfunction

  function automatic outs_t base_mask();
    outs_t m = '0;
    m.pc_write = 1'b1; m.ir_write = 1'b1; m.reg_write = 1'b1; m.mem_read = 1'b1;
    m.mem_write = 1'b1; m.mem_to_reg = 1'b1; m.halted = 1'b1; m.illegal = 1'b1;
    m.mem_err = 1'b1;
    return m;
  endfunction

  task automatic cmp(input string tag, input outs_t e, input outs_t m);
    logic [22:0] g, ev, mv;
    g = sample(); ev = e; mv = m;
    check(tag, {9'd0, g & mv}, {9'd0, ev & mv});
  endtask

  // Reference classification from the MIPS instruction set table.
  function automatic ref_t ref_dec(input logic [5:0] op, input logic [4:0] r,
                                   input logic [5:0] f);
    ref_t d;
    d = '{kind: KIll, link: 1'b0, aop: AluAdd, src1: 1'b0, src2: 2'd0, msize: 2'd2,
          msigned: 1'b0};
    case (op)
      6'h00: begin
        d.kind = KAluR;
        case (f)
          6'h00: begin d.aop = AluSll; d.src1 = 1'b1; end
          6'h02: begin d.aop = AluSrl; d.src1 = 1'b1; end
          6'h03: begin d.aop = AluSra; d.src1 = 1'b1; end
          6'h04: d.aop = AluSll;
          6'h06: d.aop = AluSrl;
          6'h07: d.aop = AluSra;
          6'h08: d.kind = KJumpR;
          6'h09: begin d.kind = KJumpR; d.link = 1'b1; end
          6'h0C: d.kind = KSys;
          6'h20, 6'h21: d.aop = AluAdd;
          6'h22, 6'h23: d.aop = AluSub;
          6'h24: d.aop = AluAnd;
          6'h25: d.aop = AluOr;
          6'h26: d.aop = AluXor;
          6'h27: d.aop = AluNor;
          6'h2A: d.aop = AluSlt;
          6'h2B: d.aop = AluSltu;
          default: d.kind = KIll;
        endcase
      end
      6'h01: begin
        if (r == 5'h00 || r == 5'h01) d.kind = KBranch;
        else if (r == 5'h10 || r == 5'h11) begin d.kind = KBranch; d.link = 1'b1; end
      end
      6'h02: d.kind = KJump;
      6'h03: begin d.kind = KJump; d.link = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: d.kind = KBranch;
      6'h08, 6'h09: begin d.kind = KAluI; d.src2 = 2'd1; end
      6'h0A: begin d.kind = KAluI; d.aop = AluSlt;  d.src2 = 2'd1; end
      6'h0B: begin d.kind = KAluI; d.aop = AluSltu; d.src2 = 2'd1; end
      6'h0C: begin d.kind = KAluI; d.aop = AluAnd;  d.src2 = 2'd2; end
      6'h0D: begin d.kind = KAluI; d.aop = AluOr;   d.src2 = 2'd2; end
      6'h0E: begin d.kind = KAluI; d.aop = AluXor;  d.src2 = 2'd2; end
      6'h0F: begin d.kind = KAluI; d.aop = AluLui;  d.src2 = 2'd2; end
      6'h20: begin d.kind = KLoad; d.src2 = 2'd1; d.msize = 2'd0; d.msigned = 1'b1; end
      6'h21: begin d.kind = KLoad; d.src2 = 2'd1; d.msize = 2'd1; d.msigned = 1'b1; end
      6'h23: begin d.kind = KLoad; d.src2 = 2'd1; d.msize = 2'd2; end
      6'h24: begin d.kind = KLoad; d.src2 = 2'd1; d.msize = 2'd0; end
      6'h25: begin d.kind = KLoad; d.src2 = 2'd1; d.msize = 2'd1; end
      6'h28: begin d.kind = KStore; d.src2 = 2'd1; d.msize = 2'd0; end
      6'h29: begin d.kind = KStore; d.src2 = 2'd1; d.msize = 2'd1; end
      6'h2B: begin d.kind = KStore; d.src2 = 2'd1; d.msize = 2'd2; end
      default: d.kind = KIll;
    endcase
    return d;
  endfunction

  // Entered and left at a falling edge.
  task automatic do_reset();
    outs_t e;
    rst = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    e = '0;
    cmp("reset", e, base_mask());
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_halt(input logic ill, input logic merr);
    outs_t e;
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'($urandom);
      br_taken  = 1'($urandom);
      #1;
      e = '0; e.halted = 1'b1; e.illegal = ill; e.mem_err = merr;
      cmp("halt", e, base_mask());
      @(negedge clk);
    end
    do_reset();
  endtask

  // fw/mw: wait cycles before mem_ready in FETCH/MEM; > WaitMax means never ready.
  task automatic run_instr(input logic [5:0] op, input logic [4:0] r, input logic [5:0] f,
                           input int fw, input int mw, input logic br, input bit rst_mid);
    ref_t  d;
    outs_t e, m;
    logic  rdy;
    d = ref_dec(op, r, f);
    op_code = op; rt = r; funct = f;

    for (int i = 0; i <= WaitMax; i++) begin
      rdy = (i == fw);
      mem_ready = rdy;
      br_taken  = 1'($urandom);
      #1;
      e = '0; m = base_mask();
      if (!rdy && i == WaitMax) begin
        cmp("fetch_timeout", e, m);
        @(negedge clk);
        expect_halt(1'b0, 1'b1);
        return;
      end
      e.mem_read = 1'b1; e.ir_write = rdy; e.pc_write = rdy;
      if (rdy) m.pc_src = '1;
      cmp("fetch", e, m);
      @(negedge clk);
      if (rdy) break;
    end

    mem_ready = 1'($urandom);
    br_taken  = 1'($urandom);
    #1;
    e = '0; m = base_mask();
    if (d.kind == KJump || d.kind == KJumpR) begin
      e.pc_write = 1'b1; m.pc_src = '1;
      e.pc_src = (d.kind == KJump) ? 2'd2 : 2'd3;
      e.reg_write = d.link;
      if (d.link) begin
        m.reg_dst = '1;
        e.reg_dst = (d.kind == KJump) ? 2'd2 : 2'd1;
      end
    end
    cmp("decode", e, m);
    @(negedge clk);
    if (d.kind == KJump || d.kind == KJumpR) return;
    if (d.kind == KSys) begin expect_halt(1'b0, 1'b0); return; end
    if (d.kind == KIll) begin expect_halt(1'b1, 1'b0); return; end

    mem_ready = 1'($urandom);
    br_taken  = br;
    #1;
    e = '0; m = base_mask();
    if (d.kind == KBranch) begin
      e.pc_write = br; e.pc_src = 2'd1; m.pc_src = '1;
      e.reg_write = d.link;
      if (d.link) begin e.reg_dst = 2'd2; m.reg_dst = '1; end
    end else begin
      e.alu_op = d.aop; e.alu_src1 = d.src1; e.alu_src2 = d.src2;
      m.alu_op = '1; m.alu_src1 = 1'b1; m.alu_src2 = '1;
    end
    cmp("exec", e, m);
    @(negedge clk);
    if (d.kind == KBranch) return;

    if (d.kind == KLoad || d.kind == KStore) begin
      for (int i = 0; i <= WaitMax; i++) begin
        rdy = (i == mw);
        mem_ready = rdy;
        br_taken  = 1'($urandom);
        #1;
        e = '0; m = base_mask();
        if (!rdy && i == WaitMax) begin
          cmp("mem_timeout", e, m);
          @(negedge clk);
          expect_halt(1'b0, 1'b1);
          return;
        end
        e.mem_read = (d.kind == KLoad); e.mem_write = (d.kind == KStore);
        e.mem_size = d.msize; e.mem_signed = d.msigned;
        m.mem_size = '1; m.mem_signed = 1'b1;
        cmp("mem", e, m);
        if (rst_mid && !rdy) begin
          #2;
          rst = 1'b1;
          #1;
          e = '0;
          cmp("mem_rst", e, base_mask());
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        @(negedge clk);
        if (rdy) break;
      end
      if (d.kind == KStore) return;
    end

    mem_ready = 1'($urandom);
    br_taken  = 1'($urandom);
    #1;
    e = '0; m = base_mask();
    e.reg_write = 1'b1; e.mem_to_reg = (d.kind == KLoad);
    e.reg_dst = (d.kind == KAluR) ? 2'd1 : 2'd0; m.reg_dst = '1;
    if (d.kind != KLoad) begin e.alu_op = d.aop; m.alu_op = '1; end
    cmp("wb", e, m);
    @(negedge clk);
  endtask

  function automatic int rand_wait();
    if ($urandom_range(0, 29) == 0) return WaitMax + 1;
    return int'($urandom_range(0, WaitMax));
  endfunction

  initial begin
    logic [5:0] op, fn;
    logic [4:0] r;
    rst = 1'b1; op_code = '0; rt = '0; funct = '0; mem_ready = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    do_reset();

    run_instr(6'h00, 5'h00, 6'h21, 0, 0, 1'b0, 1'b0);        // ADDU
    run_instr(6'h23, 5'h00, 6'h00, 0, 3, 1'b0, 1'b0);        // LW, 3 wait cycles
    run_instr(6'h04, 5'h00, 6'h00, 0, 0, 1'b0, 1'b0);        // BEQ not taken
    run_instr(6'h04, 5'h00, 6'h00, 0, 0, 1'b1, 1'b0);        // BEQ taken
    run_instr(6'h03, 5'h00, 6'h00, 0, 0, 1'b0, 1'b0);        // JAL
    run_instr(6'h00, 5'h00, 6'h09, 1, 0, 1'b0, 1'b0);        // JALR
    run_instr(6'h01, 5'h11, 6'h00, 0, 0, 1'b0, 1'b0);        // BGEZAL not taken
    run_instr(6'h0F, 5'h00, 6'h00, 0, 0, 1'b0, 1'b0);        // LUI
    run_instr(6'h3F, 5'h00, 6'h00, 0, 0, 1'b0, 1'b0);        // illegal opcode
    run_instr(6'h00, 5'h00, 6'h21, WaitMax + 1, 0, 1'b0, 1'b0); // fetch timeout
    run_instr(6'h20, 5'h00, 6'h00, WaitMax, WaitMax, 1'b0, 1'b0); // ready at the limit
    run_instr(6'h2B, 5'h00, 6'h00, 0, WaitMax + 1, 1'b0, 1'b0);   // store timeout
    run_instr(6'h2B, 5'h00, 6'h00, 0, 2, 1'b0, 1'b1);        // reset mid-store
    run_instr(6'h00, 5'h00, 6'h21, 0, 0, 1'b0, 1'b0);        // resumes from FETCH
    run_instr(6'h00, 5'h00, 6'h0C, 0, 0, 1'b0, 1'b0);        // SYSCALL

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = 6'($urandom); r = 5'($urandom); fn = 6'($urandom);
      end else begin
        op = LegalOps[$urandom_range(0, 23)];
        r  = LegalRts[$urandom_range(0, 3)];
        fn = LegalFns[$urandom_range(0, 19)];
      end
      run_instr(op, r, fn, rand_wait(), rand_wait(), 1'($urandom),
                ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
